// File: rtl/serial_slice_comparator_if.sv
// Handshake and operand bundle for serial_slice_comparator.
// Flags are ordered {g,e,l} wherever they appear packed.
interface serial_slice_comparator_if #(
   parameter int WIDTH = 12
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             l;
   logic             e;
   logic             g;
   logic             busy;
   logic             done;
   logic             lt;
   logic             eq;
   logic             gt;

   modport master (
      output start, a, b, l, e, g,
      input  busy, done, lt, eq, gt
   );

   modport slave (
      input  start, a, b, l, e, g,
      output busy, done, lt, eq, gt
   );
endinterface

// File: rtl/serial_slice_comparator.sv
// Wide magnitude compare, one 3-bit slice per clock, LSB slice first.
// Optional: define CMP_SIGNED_EN for two's complement operands.
module serial_slice_comparator #(
   parameter int WIDTH = 12
) (
   input logic                  clk,
   input logic                  rst_n,
   serial_slice_comparator_if.slave bus
);
   localparam int N  = WIDTH / 3;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [CW-1:0]    cnt;
   logic [2:0]       flg;
   logic [2:0]       flg_nxt;
   logic [2:0]       res;
   logic [2:0]       seed;
   logic [2:0]       sa;
   logic [2:0]       sb;
   logic             last;
   logic             accept;

   assign last = (cnt == CW'(N - 1));

   // The DONE exit edge also samples start, giving one compare per N+1 cycles.
   assign accept = bus.start && (state == IDLE || state == DONE);

   // Any seed that is not one-hot collapses to "equal".
   always_comb begin
      seed = 3'b010;
      case ({bus.g, bus.e, bus.l})
         3'b100:  seed = 3'b100;
         3'b001:  seed = 3'b001;
         default: seed = 3'b010;
      endcase
   end

   // Slice compare; the top slice flips its sign bit in signed mode.
   always_comb begin
      sa = a_q[2:0];
      sb = b_q[2:0];
`ifdef CMP_SIGNED_EN
      if (last) begin
         sa[2] = ~sa[2];
         sb[2] = ~sb[2];
      end
`else
`endif
      flg_nxt = flg;
      unique case (1'b1)
         (sa > sb): flg_nxt = 3'b100;
         (sa < sb): flg_nxt = 3'b001;
         default:   flg_nxt = flg;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = RUN;
         RUN:     if (last) state_nxt = DONE;
         DONE:    state_nxt = bus.start ? RUN : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand shift registers, running flags, slice counter and result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         cnt <= '0;
         flg <= 3'b010;
         res <= 3'b000;
      end else if (accept) begin
         a_q <= bus.a;
         b_q <= bus.b;
         cnt <= '0;
         flg <= seed;
         res <= 3'b000;
      end else if (state == RUN) begin
         a_q <= a_q >> 3;
         b_q <= b_q >> 3;
         cnt <= cnt + 1'b1;
         flg <= flg_nxt;
         if (last) res <= flg_nxt;
      end
   end

   assign bus.busy = (state == RUN);
   assign bus.done = (state == DONE);
   assign bus.gt   = res[2];
   assign bus.eq   = res[1];
   assign bus.lt   = res[0];
endmodule
